sr_cmd_pulse_gen: RTL and testbench

- Upstream command stage for the SR flip-flop (s/r/clk, output q).
- Takes two raw, asynchronous request levels (set, clear) and synchronizes and debounces each one.
- Converts debounced rising edges into single-cycle, mutually exclusive s/r pulses with a minimum spacing between pulses.
- Guarantees the downstream flip-flop never sees s=r=1, so its X output state cannot occur.

---
 rtl/sr_cmd_pulse_gen.sv | 189 ++++++++++++++++++
 tb/tb_sr_cmd_pulse_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_pulse_gen.sv
// sr_cmd_pulse_gen: command front-end for a downstream SR flip-flop.
// Two raw asynchronous request levels (set_req, clr_req) are synchronized,
// debounced and edge-detected. Each edge becomes a pending command. A small
// IDLE/PULSE/HOLD FSM issues single-cycle, mutually exclusive s/r pulses
// with a guard gap after each one, so the flip-flop never sees s=r=1.
// Optional feature macro: SR_REDUNDANT_FILTER_EN. When it is defined, a
// command that would not change q_fb is discarded without a pulse.
// Bit index 0 of the per-input vectors is the set path, index 1 is clear.

module sr_cmd_pulse_gen #(
    parameter int DEB_CYCLES     = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int PRIORITY_RESET = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // The counter flips the level on the edge where it would reach DEB_CYCLES.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    // Remaining hold cycles after the first HOLD cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam bit                HAS_HOLD  = (HOLD_CYCLES > 0);
    localparam bit                CLR_WINS  = (PRIORITY_RESET != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Synchronizer, debounce and edge-detect state.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0] cnt_q [2];
    logic [DEB_W-1:0] cnt_d [2];
    logic [1:0]       rise_s;

    // Command state.
    logic [1:0]        pend_q, pend_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              busy_q, busy_d;
    logic              conflict_q, conflict_d;
    logic              win_set_s;
    logic              drop_s;

`ifndef SR_REDUNDANT_FILTER_EN
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
`endif

    // Synchronize both requests and debounce each synced level.
    always_comb begin
        sync1_d    = {clr_req, set_req};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = {DEB_W{1'b0}};
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = {DEB_W{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_d[i] = {DEB_W{1'b0}};
            end
        end
        // Debounced levels reset to 0, so a level already high at reset
        // release shows up here as a rising edge.
        rise_s = deb_q & ~deb_prev_q;
    end

    // Pending-flag bookkeeping, arbitration and pulse/hold sequencing.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pend_d     = pend_q | rise_s;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        win_set_s  = 1'b0;
        drop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'b00) begin
                    conflict_d = pend_q[0] & pend_q[1];
                    if (pend_q[0] & pend_q[1]) begin
                        win_set_s = ~CLR_WINS;
                    end else begin
                        win_set_s = pend_q[0];
                    end
                    // Every flag seen here is consumed: the winner is issued,
                    // a losing flag is dropped. Fresh edges survive.
                    pend_d = rise_s;
`ifdef SR_REDUNDANT_FILTER_EN
                    drop_s = win_set_s ? q_fb : ~q_fb;
`else
                    drop_s = 1'b0;
`endif
                    if (drop_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PULSE;
                        s_d     = win_set_s;
                        r_d     = ~win_set_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (HAS_HOLD) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LAST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == {HOLD_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = {HOLD_W{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All state registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            deb_q      <= 2'b00;
            deb_prev_q <= 2'b00;
            cnt_q[0]   <= {DEB_W{1'b0}};
            cnt_q[1]   <= {DEB_W{1'b0}};
            pend_q     <= 2'b00;
            state_q    <= ST_IDLE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            pend_q     <= pend_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_pulse_gen.sv
// Directed bench for sr_cmd_pulse_gen with default parameters
// (DEB_CYCLES=4, HOLD_CYCLES=2, PRIORITY_RESET=1). Cycle k below counts
// rising edges after the inputs change; outputs are sampled 1 time unit
// after each edge.

module tb_sr_cmd_pulse_gen;

    logic clk;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    int checks;
    int errors;

    sr_cmd_pulse_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .q_fb     (q_fb),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply reset mid-cycle and release mid-cycle; the next edge is cycle 1.
    task automatic do_reset(input logic set_lvl, input logic clr_lvl, input logic fb);
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        set_req = set_lvl;
        clr_req = clr_lvl;
        q_fb    = fb;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        q_fb    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, r, busy, conflict} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got s,r,busy,conflict=%b%b%b%b expected 0000", s, r, busy, conflict);
        end
        do_reset(1'b0, 1'b0, 1'b0);
        repeat (12) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s, r, busy, conflict} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle: got s,r,busy,conflict=%b%b%b%b expected 0000", s, r, busy, conflict);
            end
        end
    endtask

    task automatic test_single_set();
        logic exp_s;
        logic exp_busy;
        do_reset(1'b0, 1'b0, 1'b0);
        set_req = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            exp_s    = (k == 8) ? 1'b1 : 1'b0;
            exp_busy = (k >= 8 && k <= 10) ? 1'b1 : 1'b0;
            checks++;
            if (s !== exp_s) begin
                errors++;
                $display("FAIL single_set_s cycle %0d: got %b expected %b", k, s, exp_s);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL single_set_busy cycle %0d: got %b expected %b", k, busy, exp_busy);
            end
            checks++;
            if ({r, conflict} !== 2'b00) begin
                errors++;
                $display("FAIL single_set_r cycle %0d: got r,conflict=%b%b expected 00", k, r, conflict);
            end
        end
        // Falling edge of the debounced level produces nothing.
        set_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s, r, busy} !== 3'b000) begin
                errors++;
                $display("FAIL set_fall cycle %0d: got s,r,busy=%b%b%b expected 000", k, s, r, busy);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(1'b0, 1'b0, 1'b0);
        set_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                set_req = 1'b0;
            end else begin
                set_req = set_req;
            end
            checks++;
            if ({s, r, busy} !== 3'b000) begin
                errors++;
                $display("FAIL glitch cycle %0d: got s,r,busy=%b%b%b expected 000", k, s, r, busy);
            end
        end
    endtask

    task automatic test_conflict();
        logic exp_hit;
        logic exp_busy;
        do_reset(1'b0, 1'b0, 1'b0);
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_hit  = (k == 8) ? 1'b1 : 1'b0;
            exp_busy = (k >= 8 && k <= 10) ? 1'b1 : 1'b0;
            checks++;
            if (r !== exp_hit) begin
                errors++;
                $display("FAIL conflict_r cycle %0d: got %b expected %b", k, r, exp_hit);
            end
            checks++;
            if (conflict !== exp_hit) begin
                errors++;
                $display("FAIL conflict_flag cycle %0d: got %b expected %b", k, conflict, exp_hit);
            end
            checks++;
            if (s !== 1'b0) begin
                errors++;
                $display("FAIL conflict_s cycle %0d: got %b expected 0", k, s);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL conflict_busy cycle %0d: got %b expected %b", k, busy, exp_busy);
            end
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_s;
        logic exp_r;
        logic exp_busy;
        logic prev_sr;
        do_reset(1'b0, 1'b0, 1'b0);
        set_req = 1'b1;
        prev_sr = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            // Clear sampled from cycle 4: its edge lands during the set's HOLD.
            if (k == 3) begin
                clr_req = 1'b1;
            end else begin
                clr_req = clr_req;
            end
            exp_s    = (k == 8) ? 1'b1 : 1'b0;
            exp_r    = (k == 12) ? 1'b1 : 1'b0;
            exp_busy = ((k >= 8 && k <= 10) || (k >= 12 && k <= 14)) ? 1'b1 : 1'b0;
            checks++;
            if (s !== exp_s) begin
                errors++;
                $display("FAIL b2b_s cycle %0d: got %b expected %b", k, s, exp_s);
            end
            checks++;
            if (r !== exp_r) begin
                errors++;
                $display("FAIL b2b_r cycle %0d: got %b expected %b", k, r, exp_r);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d: got %b expected %b", k, busy, exp_busy);
            end
            checks++;
            if (((s & r) !== 1'b0) || (prev_sr && (s | r))) begin
                errors++;
                $display("FAIL b2b_exclusive cycle %0d: got s=%b r=%b prev=%b expected exclusive single pulses", k, s, r, prev_sr);
            end
            prev_sr = s | r;
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        do_reset(1'b0, 1'b0, 1'b0);
        set_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_s: got %b expected 1", s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, busy} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_drop: got s,busy=%b%b expected 00", s, busy);
        end
        set_req = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s, r, busy} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: got s,r,busy=%b%b%b expected 000", k, s, r, busy);
            end
        end
        // A request already high at release is treated as a fresh edge.
        do_reset(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s !== ((k == 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL release_high_s cycle %0d: got %b expected %b", k, s, (k == 8) ? 1'b1 : 1'b0);
            end
        end
        set_req = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_redundant_filter();
        logic exp_s;
        logic exp_busy;
        do_reset(1'b0, 1'b0, 1'b1);
        set_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
`ifdef SR_REDUNDANT_FILTER_EN
            exp_s    = 1'b0;
            exp_busy = 1'b0;
`else
            exp_s    = (k == 8) ? 1'b1 : 1'b0;
            exp_busy = (k >= 8 && k <= 10) ? 1'b1 : 1'b0;
`endif
            checks++;
            if (s !== exp_s) begin
                errors++;
                $display("FAIL filter_s cycle %0d: got %b expected %b", k, s, exp_s);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL filter_busy cycle %0d: got %b expected %b", k, busy, exp_busy);
            end
        end
        set_req = 1'b0;
        q_fb    = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_set();
        test_glitch();
        test_conflict();
        test_back_to_back();
        test_reset_mid_pulse();
        test_redundant_filter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
